// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: active-high glyph table and width helper.
// Combinational only; no state, no flow control.
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // Entry 0 is rightmost; bit6=a ... bit0=g, b and d are lowercase glyphs.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
        7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
    };

    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/seg_mux_n_hex7seg.sv
// Hex nibble to active-high seven-segment pattern (bit6=a .. bit0=g).
// Purely combinational, zero latency; no backpressure.
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] nib_dat,
    output logic [6:0] seg_dat
);

    assign seg_dat = SEG_TABLE[nib_dat];

endmodule

// File: rtl/seg_mux_n.sv
// Multiplexed N-digit seven-segment scanner with frame-synchronous loading, LZ blanking, PWM dimming and dead-time.
// All outputs registered one clk after the slot state that selects them; free-running scan, never stalls.
module seg_mux_n
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYC    = 4,
    parameter int BRIGHT_W    = 4,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   en_mask,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              a_to_g,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int IDX_W   = clog2(NUM_DIGITS);
    localparam int PRESC_W = clog2(REFRESH_DIV);
    localparam logic POL   = (ACTIVE_LOW != 0);

    localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [PRESC_W-1:0]    DEAD_END   = PRESC_W'(DEAD_CYC);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{POL}};
    localparam logic [6:0]            SEG_IDLE   = SEG_OFF ^ {7{POL}};

    logic [PRESC_W-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [BRIGHT_W-1:0]     pwm_q, pwm_d;
    logic [4*NUM_DIGITS-1:0] hold_dat_q, hold_dat_d, disp_dat_q, disp_dat_d;
    logic [NUM_DIGITS-1:0]   hold_dp_q, hold_dp_d, disp_dp_q, disp_dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    frame_done_q, frame_done_d;

    logic                    slot_end;
    logic                    frame_wrap;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   an_vec;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic [6:0]              cur_seg;

    assign cur_nib = disp_dat_q[4*int'(idx_q) +: 4];
    assign cur_dp  = disp_dp_q[idx_q];

    hex7seg u_hex7seg (
        .nib_dat (cur_nib),
        .seg_dat (cur_seg)
    );

    // Scan from the most significant digit down; a digit is blanked while everything above it is zero.
    always_comb begin
        zero_run = 1'b1;
        lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run    = zero_run && (disp_dat_q[4*i +: 4] == 4'h0) && !disp_dp_q[i];
            lz_blank[i] = blank_lz && (i != 0) && zero_run;
        end
    end

    always_comb begin
        slot_end   = (presc_q == PRESC_LAST);
        frame_wrap = slot_end && (idx_q == IDX_LAST);

        presc_d = slot_end ? '0 : presc_q + PRESC_W'(1);
        idx_d   = idx_q;
        if (slot_end) begin
            idx_d = frame_wrap ? '0 : idx_q + IDX_W'(1);
        end
        pwm_d = pwm_q + BRIGHT_W'(1);

        hold_dat_d = load ? digits_in : hold_dat_q;
        hold_dp_d  = load ? dp_in : hold_dp_q;
        // Display picks up the pre-edge hold value, so a load on the wrap edge waits one frame.
        disp_dat_d = frame_wrap ? hold_dat_q : disp_dat_q;
        disp_dp_d  = frame_wrap ? hold_dp_q : disp_dp_q;

        an_vec        = '0;
        an_vec[idx_q] = (presc_q >= DEAD_END) && (pwm_q <= brightness)
                        && en_mask[idx_q] && !lz_blank[idx_q];

        an_d         = an_vec ^ AN_OFF;
        seg_d        = cur_seg ^ {7{POL}};
        dp_d         = cur_dp ^ POL;
        frame_done_d = frame_wrap;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q      <= '0;
            idx_q        <= '0;
            pwm_q        <= '0;
            hold_dat_q   <= '0;
            hold_dp_q    <= '0;
            disp_dat_q   <= '0;
            disp_dp_q    <= '0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_IDLE;
            dp_q         <= POL;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            pwm_q        <= pwm_d;
            hold_dat_q   <= hold_dat_d;
            hold_dp_q    <= hold_dp_d;
            disp_dat_q   <= disp_dat_d;
            disp_dp_q    <= disp_dp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign a_to_g     = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_mux_n.sv
// Bench for seg_mux_n: directed scenarios plus random loads/controls against a time-indexed reference model.
module tb_seg_mux_n;

    localparam int N     = 4;
    localparam int DIV   = 16;
    localparam int DEAD  = 2;
    localparam int FRAME = N * DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  en_mask = 4'hF;
    logic [3:0]  brightness = 4'hF;
    logic [3:0]  an;
    logic [6:0]  a_to_g;
    logic        dp;
    logic        frame_done;

    always #5 clk = ~clk;

    seg_mux_n #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (DIV),
        .DEAD_CYC    (DEAD),
        .BRIGHT_W    (4),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .en_mask    (en_mask),
        .brightness (brightness),
        .an         (an),
        .a_to_g     (a_to_g),
        .dp         (dp),
        .frame_done (frame_done)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: elapsed cycles since reset and the data registers seen by the viewer.
    int          cnt = 0;
    int          last_fd = -1;
    int          lit_cycles = 0;
    logic        an2_lit = 1'b0;
    logic [15:0] hold_m = '0, disp_m = '0;
    logic [3:0]  hold_dp_m = '0, disp_dp_m = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] v);
        string      s;
        logic [6:0] g;
        g = '0;
        case (v)
            4'h0: s = "abcdef";   4'h1: s = "bc";      4'h2: s = "abdeg";  4'h3: s = "abcdg";
            4'h4: s = "bcfg";     4'h5: s = "acdfg";   4'h6: s = "acdefg"; 4'h7: s = "abc";
            4'h8: s = "abcdefg";  4'h9: s = "abcdfg";  4'hA: s = "abcefg"; 4'hB: s = "cdefg";
            4'hC: s = "adef";     4'hD: s = "bcdeg";   4'hE: s = "adefg";  default: s = "aefg";
        endcase
        for (int i = 0; i < s.len(); i++) begin
            g[6 - int'(s[i] - 8'h61)] = 1'b1;
        end
        return g;
    endfunction

    task automatic step();
        int         slot, presc, pwm;
        logic       blank, dp_e, fd_e;
        logic [3:0] an_e;
        logic [6:0] seg_e;
        presc = cnt % DIV;
        slot  = (cnt / DIV) % N;
        pwm   = cnt % 16;
        blank = blank_lz && (slot != 0) && ((disp_m >> (4*slot)) == 16'h0)
                && ((disp_dp_m >> slot) == 4'h0);
        an_e  = 4'hF;
        if (presc >= DEAD && pwm <= int'(brightness) && en_mask[slot] && !blank) an_e[slot] = 1'b0;
        seg_e = ~glyph(disp_m[4*slot +: 4]);
        dp_e  = ~disp_dp_m[slot];
        fd_e  = (cnt % FRAME) == FRAME - 1;
        if (fd_e) begin
            disp_m    = hold_m;
            disp_dp_m = hold_dp_m;
        end
        if (load) begin
            hold_m    = digits_in;
            hold_dp_m = dp_in;
        end
        @(posedge clk);
        @(negedge clk);
        check_val($sformatf("an@%0d", cnt), 32'(an), 32'(an_e));
        check_val($sformatf("seg@%0d", cnt), 32'(a_to_g), 32'(seg_e));
        check_val($sformatf("dp@%0d", cnt), 32'(dp), 32'(dp_e));
        check_val($sformatf("fd@%0d", cnt), 32'(frame_done), 32'(fd_e));
        if (an != 4'hF) lit_cycles++;
        if (!an[2]) an2_lit = 1'b1;
        if (frame_done) begin
            if (last_fd >= 0) check_val("fd_period", 32'(cnt - last_fd), 32'(FRAME));
            last_fd = cnt;
        end
        cnt++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        digits_in = d;
        dp_in     = p;
        load      = 1'b1;
        step();
        load      = 1'b0;
    endtask

    task automatic wait_to(input int phase);
        for (int k = 0; k < FRAME && (cnt % FRAME) != phase; k++) step();
    endtask

    // Called at a negedge; asserts reset between edges so its effect must be asynchronous.
    task automatic apply_reset();
        #2 reset = 1'b1;
        #1;
        check_val("rst_an", 32'(an), 32'h0000000F);
        check_val("rst_seg", 32'(a_to_g), 32'h0000007F);
        check_val("rst_dp", 32'(dp), 32'h00000001);
        check_val("rst_fd", 32'(frame_done), 32'h00000000);
        cnt = 0; last_fd = -1;
        hold_m = '0; disp_m = '0; hold_dp_m = '0; disp_dp_m = '0;
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        apply_reset();

        // Basic scan of 1234
        do_load(16'h1234, 4'h0);
        run(2 * FRAME);

        // Leading-zero blanking, including a dp that keeps a zero digit lit
        blank_lz = 1'b1;
        do_load(16'h0050, 4'h0);
        run(2 * FRAME);
        do_load(16'h0000, 4'h0);
        run(2 * FRAME);
        do_load(16'h0000, 4'b0100);
        run(2 * FRAME);
        blank_lz = 1'b0;

        // Tear-free: load mid slot 1, then a load exactly on the wrap edge
        wait_to(DIV + 4);
        do_load(16'hAAAA, 4'h0);
        run(FRAME);
        wait_to(FRAME - 1);
        do_load(16'h5C3E, 4'h9);
        run(2 * FRAME);

        // Brightness 3: two lit cycles per slot (prescaler 2 and 3)
        brightness = 4'd3;
        wait_to(0);
        lit_cycles = 0;
        run(4 * FRAME);
        check_val("bright_lit", 32'(lit_cycles), 32'(4 * N * (3 + 1 - DEAD)));
        brightness = 4'hF;

        // Masked digit 2, then an asynchronous reset in the middle of slot 2
        en_mask = 4'b1011;
        wait_to(0);
        an2_lit = 1'b0;
        run(2 * FRAME);
        check_val("an2_dark", 32'(an2_lit), 32'h0);
        en_mask = 4'hF;
        wait_to(2 * DIV + 5);
        apply_reset();
        run(FRAME + 4);

        // Random loads and live control changes
        for (int k = 0; k < 1500; k++) begin
            load = ($urandom_range(0, 11) == 0);
            if (load) begin
                digits_in = 16'($urandom);
                dp_in     = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                if ($urandom_range(0, 1) == 1) digits_in[15:8] = 8'h00;
            end
            if ($urandom_range(0, 40) == 0) blank_lz = 1'($urandom);
            if ($urandom_range(0, 40) == 0) en_mask = 4'($urandom);
            if ($urandom_range(0, 40) == 0) brightness = 4'($urandom);
            step();
        end
        load = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_mux_n.md
Name: seg_mux_n

Overview:
- Parametrised seven-segment display scanner that drives NUM_DIGITS multiplexed digits from a packed hex value.
- Sits between the PicoBlaze subsystem's digit outputs and the board's anode and segment pins.
- Replaces the fixed 4-digit scanner and its external clock divider, and adds:
  - an internal refresh prescaler
  - tear-free frame-synchronous loading
  - leading-zero blanking
  - per-digit enable mask
  - decimal points
  - PWM brightness control
  - anode dead-time

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8)
- REFRESH_DIV, 50000, clk cycles per digit slot (>= 2*DEAD_CYC+2)
- DEAD_CYC, 4, cycles at slot start with all anodes inactive (anti-ghosting)
- BRIGHT_W, 4, width of brightness control
- ACTIVE_LOW, 1, 1 = an/a_to_g/dp pins active-low, 0 = active-high

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- digits_in  input  4*NUM_DIGITS  packed hex nibbles; nibble i = digit i, digit 0 rightmost
- dp_in  input  NUM_DIGITS  decimal point per digit
- load  input  1  single-cycle strobe: capture digits_in/dp_in into hold register
- blank_lz  input  1  enable leading-zero blanking
- en_mask  input  NUM_DIGITS  per-digit enable; 0 forces that digit dark
- brightness  input  BRIGHT_W  duty control; all-ones = full on
- an  output  NUM_DIGITS  anode drives
- a_to_g  output  7  segments; bit6=a … bit0=g
- dp  output  1  decimal point segment
- frame_done  output  1  one-cycle pulse when the last slot of a frame ends

Behaviour:
- Reset (asynchronous, immediate, including mid-frame):
  - an and a_to_g all inactive; dp inactive; frame_done=0.
  - Prescaler=0, slot index=0, pwm counter=0.
  - Hold and display registers cleared (0 data, dp 0).
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. At the terminal count the slot index advances.
- Slot index:
  - Wraps from NUM_DIGITS-1 to 0.
  - On that wrap, frame_done pulses for the same cycle.
  - On that wrap, the display register takes the hold register.
- Load:
  - load=1 writes the hold register at that clock edge.
  - The display changes only at the next frame wrap, so there is no mid-frame tearing.
  - If load coincides with the wrap edge, the display takes the old hold value and the new value shows one frame later.
  - Multiple loads within a frame: the last one wins.
- pwm counter: BRIGHT_W bits, free-running, increments every clk, wraps.
- Anode for the current slot i is active iff all of the following hold:
  - prescaler >= DEAD_CYC
  - pwm counter <= brightness
  - en_mask[i]=1
  - digit i is not LZ-blanked
- All other anodes are inactive.
- Leading-zero blanking: digit i is blanked iff all of the following hold:
  - blank_lz=1
  - i != 0
  - display nibbles i..NUM_DIGITS-1 are all 0
  - display dp bits i..NUM_DIGITS-1 are all 0
  - Digit 0 is never blanked.
- Segments:
  - a_to_g is the hex decode (0-F, standard 7-segment glyphs, b/d lowercase) of display nibble i.
  - dp = display dp bit i.
  - Both are polarity-adjusted by ACTIVE_LOW.
  - Segments are driven regardless of anode gating.
- Latency: all outputs are registered, one clk after the prescaler/index state that selects them.
- en_mask, blank_lz and brightness are sampled live (not frame-synchronised).

Decomposition:
- Package seg_pkg:
  - 16-entry hex-to-segment constant table (active-high, bit6=a)
  - SEG_OFF constant
  - clog2 helper for the index and prescaler widths
- Sub-module hex7seg: combinational nibble -> 7-bit pattern, active-high. The top applies polarity.

Test Plan:
(Bench parameters: NUM_DIGITS=4, REFRESH_DIV=16, DEAD_CYC=2, BRIGHT_W=4, ACTIVE_LOW=1.)
1. Reset:
   - Assert reset -> an=4'b1111, a_to_g=7'b1111111, dp=1, frame_done=0.
   - Outputs reach these values asynchronously, without waiting for a clk edge.
2. Basic scan:
   - Stimulus: load digits_in=16'h1234, brightness=4'hF, en_mask=4'hF.
   - After the next frame wrap, slot0: an=4'b1110 from slot cycle 3, a_to_g=7'b1001100 ("4"). Slots 1, 2 and 3 show 3, 2 and 1.
   - frame_done pulses every 64 cycles.
3. Leading zeros:
   - Stimulus: blank_lz=1, load 16'h0050.
   - Digits 3 and 2 are dark; digit1 shows "5"; digit0 shows "0".
   - Load 16'h0000: only digit0 lit.
   - Set dp_in[2]=1: digit2 lit as "0." while digit3 stays dark.
4. Tear-free load:
   - Stimulus: load 16'hAAAA mid-frame during slot 1.
   - Slots 2 and 3 still show the old values; "A" appears from slot0 of the next frame.
   - A load on the wrap edge appears one frame later.
5. Brightness and dead-time:
   - Stimulus: brightness=3.
   - Within each 16-cycle slot, the anode is active only on cycles with prescaler>=2 and pwm counter<=3.
   - Expected count over 4 frames: 4 of every 16 pwm phases, excluding dead cycles.
6. Mask and mid-frame reset:
   - Stimulus: en_mask=4'b1011.
   - an[2] never goes active; the other anodes scan normally.
   - Pulse reset during slot 2: outputs go off immediately, and the scan restarts at slot0 with cleared display.
